datapath_arbiter: RTL and testbench

//  Shares the single ALU/register datapath between the three clock controllers
//  (0 = timer set, 1 = time update, 2 = timer compare).

---
 rtl/datapath_arbiter_pkg.sv | 37 +++
 rtl/datapath_arbiter_rr_pick.sv | 41 ++++
 rtl/datapath_arbiter.sv | 147 ++++++++++++++
 tb/tb_datapath_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_arbiter_pkg.sv
// Shared definitions for the clock datapath arbiter.
//   - requester IDs of the three clock controllers
//   - arbiter FSM state encoding
//   - bit positions of the datapath strobe bundle
//   - one-hot to requester-ID helper
package datapath_arbiter_pkg;

    localparam int unsigned NumReq = 3;

    // Requester IDs
    localparam logic [1:0] ReqSet = 2'd0;  // timer set controller
    localparam logic [1:0] ReqUpd = 2'd1;  // time update controller (urgent)
    localparam logic [1:0] ReqCmp = 2'd2;  // timer compare controller

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StRelease = 2'd2
    } state_e;

    // Strobe bundle {la, lb, ea, lr, er}
    localparam int unsigned StbW  = 5;
    localparam int unsigned StbLa = 4;
    localparam int unsigned StbLb = 3;
    localparam int unsigned StbEa = 2;
    localparam int unsigned StbLr = 1;
    localparam int unsigned StbEr = 0;

    function automatic logic [1:0] onehot_to_id(input logic [NumReq-1:0] oh);
        logic [1:0] id;
        id = ReqSet;
        if (oh[1]) id = ReqUpd;
        if (oh[2]) id = ReqCmp;
        return id;
    endfunction

endpackage

// File: rtl/datapath_arbiter_rr_pick.sv
// Combinational 3-way winner picker.
//   req_i   : per-controller request levels
//   last_i  : ID of the most recent owner (search starts at last_i + 1)
//   win_o   : one-hot winner, zero when nothing is requesting
// Requester 1 (time update) is urgent: it outranks requester 2 whenever it did not
// own the datapath last, and it never wins twice in a row while anyone else waits.
// Together with the fairness requirement that full load rotates 0,1,2,0,... this
// is exactly the rotation order below, so the override is folded into the tables.
module datapath_arbiter_rr_pick
    import datapath_arbiter_pkg::*;
(
    input  logic [NumReq-1:0] req_i,
    input  logic [1:0]        last_i,
    output logic [NumReq-1:0] win_o
);

    always_comb begin
        win_o = '0;
        unique case (last_i)
            ReqSet: begin
                // order 1, 2, 0
                if (req_i[1])      win_o = 3'b010;
                else if (req_i[2]) win_o = 3'b100;
                else if (req_i[0]) win_o = 3'b001;
            end
            ReqUpd: begin
                // order 2, 0, 1: urgent requester yields after its own grant
                if (req_i[2])      win_o = 3'b100;
                else if (req_i[0]) win_o = 3'b001;
                else if (req_i[1]) win_o = 3'b010;
            end
            default: begin
                // order 0, 1, 2 (also the post-reset search order)
                if (req_i[0])      win_o = 3'b001;
                else if (req_i[1]) win_o = 3'b010;
                else if (req_i[2]) win_o = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/datapath_arbiter.sv
// Grants the shared ALU/register datapath to one clock controller at a time.
//   clk, rst_n          : clock, synchronous active-low reset
//   req, done           : per-controller request level and last-cycle flag
//   la_in..er_in        : per-controller datapath strobes
//   sel_in, cin_in      : per-controller ALU select and carry-in
//   gnt                 : registered one-hot grant
//   la, lb, ea, lr, er  : owner strobes (0 without grant)
//   alu_sel, alu_cin    : owner ALU controls (0 without grant)
//   busy                : high while a grant is active
//   timeout             : one-cycle pulse on the owner bit when the hold limit expires
module datapath_arbiter
    import datapath_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            req,
    input  logic [2:0]            done,
    input  logic [2:0]            la_in,
    input  logic [2:0]            lb_in,
    input  logic [2:0]            ea_in,
    input  logic [2:0]            lr_in,
    input  logic [2:0]            er_in,
    input  logic [3*SEL_W-1:0]    sel_in,
    input  logic [2:0]            cin_in,
    output logic [2:0]            gnt,
    output logic                  la,
    output logic                  lb,
    output logic                  ea,
    output logic                  lr,
    output logic                  er,
    output logic [SEL_W-1:0]      alu_sel,
    output logic                  alu_cin,
    output logic                  busy,
    output logic [2:0]            timeout
);

    state_e              state_q, state_d;
    logic [2:0]          gnt_q, gnt_d;
    logic [1:0]          last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [2:0]          win;
    logic                owner_req;
    logic                owner_done;
    logic [StbW-1:0]     stb;

    datapath_arbiter_rr_pick u_rr_pick (
        .req_i  (req),
        .last_i (last_q),
        .win_o  (win)
    );

    // gnt_q is one-hot or zero, so AND-OR selects the owner's bit without indexing.
    assign owner_req  = |(gnt_q & req);
    assign owner_done = |(gnt_q & done);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        hold_d  = hold_q;
        stb     = '0;
        alu_sel = '0;
        alu_cin = 1'b0;
        timeout = '0;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StGrant;
                    gnt_d   = win;
                    last_d  = onehot_to_id(win);
                end
            end

            StGrant: begin
                hold_d = hold_q + HOLD_W'(1);
                if (owner_req) begin
                    stb[StbLa] = |(gnt_q & la_in);
                    stb[StbLb] = |(gnt_q & lb_in);
                    stb[StbEa] = |(gnt_q & ea_in);
                    stb[StbLr] = |(gnt_q & lr_in);
                    stb[StbEr] = |(gnt_q & er_in);
                    alu_cin    = |(gnt_q & cin_in);
                    for (int i = 0; i < 3; i++) begin
                        if (gnt_q[i]) alu_sel = alu_sel | sel_in[i*SEL_W +: SEL_W];
                    end
                end
                // done wins over a simultaneous req drop; timeout only if neither happened
                if (owner_done || !owner_req) begin
                    state_d = StRelease;
                    gnt_d   = '0;
                end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    timeout = gnt_q;
                    state_d = StRelease;
                    gnt_d   = '0;
                end
            end

            StRelease: begin
                // one dead cycle on the datapath before the next owner drives it
                hold_d = '0;
                gnt_d  = '0;
                if (|req) begin
                    state_d = StGrant;
                    gnt_d   = win;
                    last_d  = onehot_to_id(win);
                end else begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            last_q  <= ReqCmp;  // first search after reset starts at requester 0
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q == StGrant);
    assign la   = stb[StbLa];
    assign lb   = stb[StbLb];
    assign ea   = stb[StbEa];
    assign lr   = stb[StbLr];
    assign er   = stb[StbEr];

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter. The driver applies one vector per cycle and
// pushes that cycle's expected outputs into a queue; a monitor on the falling edge
// pops and compares against the DUT.
module tb_datapath_arbiter;

    localparam int unsigned SEL_W = 2;

    logic               clk;
    logic               rst_n;
    logic [2:0]         req, done;
    logic [2:0]         la_in, lb_in, ea_in, lr_in, er_in, cin_in;
    logic [3*SEL_W-1:0] sel_in;
    logic [2:0]         gnt, timeout;
    logic               la, lb, ea, lr, er, alu_cin, busy;
    logic [SEL_W-1:0]   alu_sel;

    typedef struct {
        logic [14:0] v;   // {gnt, la, lb, ea, lr, er, alu_sel, alu_cin, busy, timeout}
        int          step;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step   = 0;

    datapath_arbiter #(
        .MAX_HOLD (16),
        .HOLD_W   (5),
        .SEL_W    (SEL_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .la_in   (la_in),
        .lb_in   (lb_in),
        .ea_in   (ea_in),
        .lr_in   (lr_in),
        .er_in   (er_in),
        .sel_in  (sel_in),
        .cin_in  (cin_in),
        .gnt     (gnt),
        .la      (la),
        .lb      (lb),
        .ea      (ea),
        .lr      (lr),
        .er      (er),
        .alu_sel (alu_sel),
        .alu_cin (alu_cin),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background strobes: each controller drives a distinct pattern.
    //   ctrl0: la ea,       sel 1, cin 0
    //   ctrl1: lb ea lr,    sel 2, cin 1
    //   ctrl2: la lr er,    sel 3, cin 0
    task automatic set_background();
        la_in  = 3'b101;
        lb_in  = 3'b010;
        ea_in  = 3'b011;
        lr_in  = 3'b110;
        er_in  = 3'b100;
        sel_in = {2'd3, 2'd2, 2'd1};
        cin_in = 3'b010;
    endtask

    // One cycle: apply inputs, queue the expected outputs for this cycle.
    // Expected strobes come from the bench's own inputs for the owner named in eg.
    task automatic cyc(input logic rn, input logic [2:0] rq, input logic [2:0] dn,
                       input logic [2:0] eg, input logic eb, input logic [2:0] et);
        exp_t       e;
        logic [4:0] s;
        logic [1:0] sl;
        logic       c;
        int         o;
        @(posedge clk);
        #1;
        rst_n = rn;
        req   = rq;
        done  = dn;
        s  = '0;
        sl = '0;
        c  = 1'b0;
        o  = -1;
        if (eg == 3'b001) o = 0;
        if (eg == 3'b010) o = 1;
        if (eg == 3'b100) o = 2;
        if (o >= 0 && rq[o]) begin
            s  = {la_in[o], lb_in[o], ea_in[o], lr_in[o], er_in[o]};
            sl = sel_in[o*SEL_W +: SEL_W];
            c  = cin_in[o];
        end
        step++;
        e.v    = {eg, s, sl, c, eb, et};
        e.step = step;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [14:0] got;
            e   = exp_q.pop_front();
            got = {gnt, la, lb, ea, lr, er, alu_sel, alu_cin, busy, timeout};
            n_chk++;
            if (got !== e.v) begin
                n_fail++;
                $display("FAIL outputs step %0d: got %b required %b", e.step, got, e.v);
            end
            n_chk++;
            if (!$onehot0(gnt)) begin
                n_fail++;
                $display("FAIL gnt_onehot step %0d: got %b required at most one bit", e.step,
                         gnt);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        set_background();

        // Reset state
        cyc(0, 3'b000, 3'b000, 3'b000, 0, 3'b000);
        cyc(0, 3'b000, 3'b000, 3'b000, 0, 3'b000);

        // T1: single request, done on third grant cycle
        cyc(1, 3'b000, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b001, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b001, 3'b000, 3'b001, 1, 3'b000);
        cyc(1, 3'b001, 3'b000, 3'b001, 1, 3'b000);
        cyc(1, 3'b001, 3'b001, 3'b001, 1, 3'b000);
        cyc(1, 3'b000, 3'b000, 3'b000, 0, 3'b000);  // release
        cyc(1, 3'b000, 3'b000, 3'b000, 0, 3'b000);  // idle

        // T2: all requesting after reset -> 0,1,2,0 with a dead cycle between
        cyc(0, 3'b000, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b111, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b111, 3'b000, 3'b001, 1, 3'b000);
        cyc(1, 3'b111, 3'b001, 3'b001, 1, 3'b000);
        cyc(1, 3'b111, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b111, 3'b000, 3'b010, 1, 3'b000);
        cyc(1, 3'b111, 3'b010, 3'b010, 1, 3'b000);
        cyc(1, 3'b111, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b111, 3'b000, 3'b100, 1, 3'b000);
        cyc(1, 3'b111, 3'b100, 3'b100, 1, 3'b000);
        cyc(1, 3'b111, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b111, 3'b000, 3'b001, 1, 3'b000);
        cyc(1, 3'b111, 3'b001, 3'b001, 1, 3'b000);
        cyc(1, 3'b000, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b000, 3'b000, 3'b000, 0, 3'b000);

        // T3: owner 0, then req[1] rises while 2 waits; 1 is next
        cyc(1, 3'b001, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b101, 3'b000, 3'b001, 1, 3'b000);
        cyc(1, 3'b111, 3'b000, 3'b001, 1, 3'b000);
        cyc(1, 3'b111, 3'b001, 3'b001, 1, 3'b000);
        cyc(1, 3'b110, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b110, 3'b010, 3'b010, 1, 3'b000);
        cyc(1, 3'b100, 3'b000, 3'b000, 0, 3'b000);

        // T4: owner 2 never signals done -> timeout on 16th grant cycle, then re-granted
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 3'b100, 3'b000, 3'b100, 1, (i == 16) ? 3'b100 : 3'b000);
        end
        cyc(1, 3'b100, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b100, 3'b100, 3'b100, 1, 3'b000);
        cyc(1, 3'b000, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b000, 3'b000, 3'b000, 0, 3'b000);

        // T5: owner 1 drives only la; 0 and 2 drive everything; non-owner done ignored
        la_in  = 3'b111;
        lb_in  = 3'b101;
        ea_in  = 3'b101;
        lr_in  = 3'b101;
        er_in  = 3'b101;
        sel_in = {2'd3, 2'd2, 2'd3};
        cin_in = 3'b101;
        cyc(1, 3'b010, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b111, 3'b000, 3'b010, 1, 3'b000);
        cyc(1, 3'b111, 3'b101, 3'b010, 1, 3'b000);
        cyc(1, 3'b111, 3'b010, 3'b010, 1, 3'b000);
        cyc(1, 3'b000, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b000, 3'b000, 3'b000, 0, 3'b000);
        set_background();

        // T7: owner drops req without done -> strobes masked that cycle, then release
        cyc(1, 3'b001, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b001, 3'b000, 3'b001, 1, 3'b000);
        cyc(1, 3'b000, 3'b000, 3'b001, 1, 3'b000);
        cyc(1, 3'b000, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b000, 3'b000, 3'b000, 0, 3'b000);

        // T6: reset mid-grant, then lowest active requester wins
        cyc(1, 3'b100, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b100, 3'b000, 3'b100, 1, 3'b000);
        cyc(0, 3'b100, 3'b000, 3'b100, 1, 3'b000);
        cyc(0, 3'b111, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b111, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b111, 3'b001, 3'b001, 1, 3'b000);
        cyc(1, 3'b000, 3'b000, 3'b000, 0, 3'b000);
        cyc(1, 3'b000, 3'b000, 3'b000, 0, 3'b000);

        // Drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
